bk_sum_accumulator: RTL and testbench
=====================================

// Module: bk_sum_accumulator
// PURPOSE
// - Sequential stage directly downstream of the 12-bit Brent-Kung adder.
// - Captures each 13-bit adder result (OUTS[12:0]) under a valid/ready handshake.
// - Accumulates FRAME_LEN consecutive results into a saturating sum.
// - Presents each frame total on a held valid/ready output, so the combinational adder can run every cycle.
// PARAMETERS
// - SUM_W      13   width of the adder result bus (carry-out is the MSB)
// - FRAME_LEN  8    results summed per frame; must be >= 2
// - ACC_W      16   accumulator/result width; must be >= SUM_W
// - CNT_W      $clog2(FRAME_LEN)   sample counter width (derived)
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - clr        in   1      synchronous flush of the frame in progress and any pending result
// - sum_in     in   SUM_W  adder result, bit 12 = carry-out
// - in_valid   in   1      sum_in is valid this cycle
// - in_ready   out  1      stage accepts sum_in this cycle
// - acc_out    out  ACC_W  frame total; stable while out_valid=1
// - sat        out  1      frame total saturated; qualified by out_valid
// - out_valid  out  1      acc_out/sat valid
// - out_ready  in   1      consumer takes acc_out this cycle
// BEHAVIOUR
// - Reset (rst_n=0, async): state=ACC, acc=0, cnt=0, acc_out=0, sat=0, out_valid=0.
//   - in_ready=1 while in reset (state ACC, clr low).
// - FSM states: ACC (collecting, no pending result) and HOLD (result pending).
// - in_ready = ~clr & (state==ACC | out_ready).
//   - Combinational from state, clr and out_ready only; never depends on in_valid.
// - accept = in_valid & in_ready. On accept:
//   - next = acc + zero-extended sum_in.
//   - If next > 2^ACC_W-1: acc saturates to all-ones and the per-frame sticky sat_acc is set.
//   - If cnt != FRAME_LEN-1: acc <= next, cnt <= cnt+1.
//   - If cnt == FRAME_LEN-1:
//     - acc_out <= next (saturated); sat <= sat_acc | overflow on this add.
//     - out_valid <= 1; state <= HOLD.
//     - acc, cnt and sat_acc return to 0.
// - Latency: out_valid rises the cycle after the accepting edge of sample FRAME_LEN.
// - HOLD state:
//   - acc_out/sat/out_valid held until out_valid & out_ready.
//   - Samples for the next frame are accepted only in cycles with out_ready=1.
// - Output handshake (out_valid & out_ready):
//   - If that cycle also completes a new frame: acc_out is reloaded, out_valid stays 1, state stays HOLD.
//   - Otherwise: out_valid <= 0, state <= ACC.
//   - acc_out keeps its last value after out_valid falls.
// - Throughput: one result per FRAME_LEN cycles with out_ready tied high; no bubbles.
// - clr=1 (synchronous, highest priority after reset):
//   - acc=0, cnt=0, sat_acc=0, out_valid=0, state=ACC; acc_out/sat keep their values.
//   - Any sample presented that cycle is not accepted (in_ready=0).
// - Reset or clr mid-frame discards partial sums; no partial result is ever emitted.
// - sum_in is not range-checked; any 13-bit value is summed as unsigned.
// TESTING
// - Reset: hold rst_n=0 with in_valid=1 and toggling clk.
//   -> out_valid=0, acc_out=0, sat=0; no sample counted.
// - Back-to-back: 8 samples of 100, in_valid=1, out_ready=1.
//   -> out_valid=1 exactly 1 cycle after the 8th accept; acc_out=800, sat=0; in_ready stays 1.
// - Backpressure: complete a frame of 8x5 with out_ready=0.
//   -> acc_out=40 held, in_ready=0 for 10 cycles.
//   -> raise out_ready: handshake, and sample 1 of the next frame is accepted in that same cycle.
// - Saturation: FRAME_LEN=16, 16 samples of 8190.
//   -> acc_out=65535, sat=1; the next frame of 16x1 gives acc_out=16, sat=0.
// - clr mid-frame: 3 samples of 7, then clr=1 with in_valid=1, then 8 samples of 1.
//   -> the clr-cycle sample is dropped; single result acc_out=8.
// - Async reset after 5 accepts, then 8 samples of 2.
//   -> no output from the aborted frame; acc_out=16.

Source files
------------

// File: rtl/bk_sum_accumulator.sv
// Frame accumulator behind the Brent-Kung adder: sums FRAME_LEN results with saturation
// and holds each frame total on a valid/ready output.
module bk_sum_accumulator #(
  parameter int unsigned SUM_W     = 13,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_acc_q;
  logic [ACC_W-1:0] acc_out_q;
  logic             sat_q;

  logic             accept;
  logic             last;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W:0]   next_wide;
  logic             ovf;
  logic [ACC_W-1:0] next_sat;

  // A pending result only blocks intake when the consumer is not draining it this cycle.
  assign in_ready  = ~clr & ((state_q == StAcc) | out_ready);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q == LastCnt);

  assign sum_ext   = (ACC_W + 1)'(sum_in);
  assign next_wide = {1'b0, acc_q} + sum_ext;
  assign ovf       = next_wide[ACC_W];
  assign next_sat  = ovf ? {ACC_W{1'b1}} : next_wide[ACC_W-1:0];

  assign out_valid = (state_q == StHold);
  assign acc_out   = acc_out_q;
  assign sat       = sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
      acc_out_q <= '0;
      sat_q     <= 1'b0;
    end else if (clr) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_acc_q <= 1'b0;
    end else begin
      if ((state_q == StHold) && out_ready) begin
        state_q <= StAcc;
      end
      // Completing a frame overrides the drain above, so a reload keeps the output valid.
      if (accept) begin
        if (last) begin
          acc_out_q <= next_sat;
          sat_q     <= sat_acc_q | ovf;
          state_q   <= StHold;
          acc_q     <= '0;
          cnt_q     <= '0;
          sat_acc_q <= 1'b0;
        end else begin
          acc_q     <= next_sat;
          cnt_q     <= cnt_q + CNT_W'(1);
          sat_acc_q <= sat_acc_q | ovf;
        end
      end
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !clr) |=> (out_valid && $stable(acc_out) && $stable(sat)));

  a_no_accept_on_clr: assert property (@(posedge clk) disable iff (!rst_n)
    clr |-> !in_ready);

endmodule

// File: tb/tb_bk_sum_accumulator.sv
// Scoreboard bench for bk_sum_accumulator: directed frames on an 8-sample and a 16-sample
// instance, with expected totals queued at stimulus time and checked by output monitors.
module tb_bk_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clr_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [12:0] sum_a = '0;
  logic        in_ready_a, sat_a, ov_a;
  logic [15:0] acc_a;

  logic        clr_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [12:0] sum_b = '0;
  logic        in_ready_b, sat_b, ov_b;
  logic [15:0] acc_b;

  bk_sum_accumulator #(.SUM_W(13), .FRAME_LEN(8), .ACC_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .sum_in(sum_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .acc_out(acc_a), .sat(sat_a), .out_valid(ov_a),
    .out_ready(out_ready_a)
  );

  bk_sum_accumulator #(.SUM_W(13), .FRAME_LEN(16), .ACC_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .sum_in(sum_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .acc_out(acc_b), .sat(sat_b), .out_valid(ov_b),
    .out_ready(out_ready_b)
  );

  int checks = 0;
  int failures = 0;
  logic [16:0] q_a[$];
  logic [16:0] q_b[$];
  logic [16:0] e_a, e_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitors: pop one expected {acc, sat} per output handshake.
  always @(negedge clk) begin
    if (rst_n && ov_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_a_unexpected: got acc=%0d sat=%0d expected no result", acc_a, sat_a);
      end else begin
        e_a = q_a.pop_front();
        chk("mon_a_acc", 32'(acc_a), 32'(e_a[16:1]));
        chk("mon_a_sat", 32'(sat_a), 32'(e_a[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_b_unexpected: got acc=%0d sat=%0d expected no result", acc_b, sat_b);
      end else begin
        e_b = q_b.pop_front();
        chk("mon_b_acc", 32'(acc_b), 32'(e_b[16:1]));
        chk("mon_b_sat", 32'(sat_b), 32'(e_b[0]));
      end
    end
  end

  // Present one sample and wait (bounded) for it to be accepted; returns #1 after that edge.
  task automatic send(input bit b, input logic [12:0] v, output bit stalled);
    bit got;
    stalled = 1'b0;
    if (b) begin
      in_valid_b = 1'b1;
      sum_b = v;
    end else begin
      in_valid_a = 1'b1;
      sum_a = v;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = b ? in_ready_b : in_ready_a;
      @(posedge clk);
      #1;
      if (got) return;
      stalled = 1'b1;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: got no accept in 50 cycles expected accept");
  endtask

  task automatic send_n(input bit b, input int n, input logic [12:0] v, output int stalls);
    bit st;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send(b, v, st);
      if (st) stalls++;
    end
  endtask

  task automatic idle(input int n);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls;
    bit st;

    // Reset held with valid samples present.
    in_valid_a = 1'b1;
    sum_a = 13'd100;
    in_valid_b = 1'b1;
    sum_b = 13'd100;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(ov_a), 32'd0);
    chk("rst_acc_out", 32'(acc_a), 32'd0);
    chk("rst_sat", 32'(sat_a), 32'd0);
    chk("rst_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Back-to-back frame of 8x100.
    out_ready_a = 1'b1;
    q_a.push_back({16'd800, 1'b0});
    send_n(1'b0, 7, 13'd100, stalls);
    chk("b2b_not_early", 32'(ov_a), 32'd0);
    send(1'b0, 13'd100, st);
    if (st) stalls++;
    chk("b2b_latency", 32'(ov_a), 32'd1);
    chk("b2b_in_ready", 32'(in_ready_a), 32'd1);
    chk("b2b_no_stall", 32'(stalls), 32'd0);
    idle(1);
    chk("b2b_drained", 32'(ov_a), 32'd0);
    idle(2);

    // Backpressure: frame of 8x5 held while out_ready is low.
    out_ready_a = 1'b0;
    q_a.push_back({16'd40, 1'b0});
    send_n(1'b0, 8, 13'd5, stalls);
    in_valid_a = 1'b1;
    sum_a = 13'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready_a), 32'd0);
      chk("bp_hold_valid", 32'(ov_a), 32'd1);
      chk("bp_hold_acc", 32'(acc_a), 32'd40);
    end
    @(posedge clk);
    #1;
    q_a.push_back({16'd24, 1'b0});
    out_ready_a = 1'b1;
    send(1'b0, 13'd3, st);
    chk("bp_same_cycle_accept", 32'(st), 32'd0);
    chk("bp_released", 32'(ov_a), 32'd0);
    chk("bp_keep_acc", 32'(acc_a), 32'd40);
    send_n(1'b0, 7, 13'd3, stalls);
    idle(3);

    // clr mid-frame: the clr-cycle sample is dropped.
    q_a.push_back({16'd8, 1'b0});
    send_n(1'b0, 3, 13'd7, stalls);
    clr_a = 1'b1;
    in_valid_a = 1'b1;
    sum_a = 13'd7;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk);
    #1;
    clr_a = 1'b0;
    chk("clr_keeps_acc_out", 32'(acc_a), 32'd24);
    chk("clr_out_valid", 32'(ov_a), 32'd0);
    send_n(1'b0, 8, 13'd1, stalls);
    idle(3);

    // Async reset after 5 accepts.
    q_a.push_back({16'd16, 1'b0});
    send_n(1'b0, 5, 13'd2, stalls);
    in_valid_a = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(ov_a), 32'd0);
    chk("arst_acc_out", 32'(acc_a), 32'd0);
    chk("arst_sat", 32'(sat_a), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_n(1'b0, 8, 13'd2, stalls);
    idle(3);

    // Saturation on the 16-sample instance, then a clean frame.
    out_ready_b = 1'b1;
    q_b.push_back({16'd65535, 1'b1});
    send_n(1'b1, 16, 13'd8190, stalls);
    q_b.push_back({16'd16, 1'b0});
    send_n(1'b1, 16, 13'd1, stalls);
    chk("sat_no_stall", 32'(stalls), 32'd0);
    idle(4);

    chk("end_q_a_empty", 32'(q_a.size()), 32'd0);
    chk("end_q_b_empty", 32'(q_b.size()), 32'd0);
    chk("end_ov_a", 32'(ov_a), 32'd0);
    chk("end_ov_b", 32'(ov_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
